// File: rtl/gpio_mux_ctrl.sv
// gpio_mux_ctrl: per-pin alternate-function pad mux with shadow/active selects and a tristate guard on routing changes
module gpio_mux_ctrl #(
    parameter int NUM_PINS = 38,
    parameter int NUM_DESIGNS = 13,
    parameter int GUARD_CYCLES = 2,
    localparam int SEL_W = $clog2(NUM_DESIGNS + 1),
    localparam int ADDR_W = $clog2(NUM_PINS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_DESIGNS*NUM_PINS-1:0] io_oeb_flat,
    input  logic [NUM_DESIGNS*NUM_PINS-1:0] io_out_flat,
    input  logic                            cfg_we,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [SEL_W-1:0]                cfg_wdata,
    output logic [SEL_W-1:0]                cfg_rdata,
    input  logic                            cfg_commit,
    output logic                            busy,
    output logic [NUM_PINS-1:0]             muxxed_io_oeb,
    output logic [NUM_PINS-1:0]             muxxed_io_out
);
    localparam int GW = GUARD_CYCLES > 0 ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIN = ADDR_W'(NUM_PINS - 1);

    logic [SEL_W-1:0] shadow_sel [NUM_PINS];
    logic [SEL_W-1:0] active_sel [NUM_PINS];
    logic [GW-1:0] guard_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] nxt_oeb, nxt_out;
    logic addr_ok, commit_ok;

    assign addr_ok = cfg_addr <= LAST_PIN;
    assign commit_ok = cfg_commit && !busy;
    assign cfg_rdata = addr_ok ? shadow_sel[cfg_addr] : '0;

    always_comb begin
        busy = 1'b0;
        for (int p = 0; p < NUM_PINS; p++) busy = busy | (guard_cnt[p] != '0);
    end

    // Guarded or invalid pins fall through to the tristate default.
    always_comb begin
        nxt_oeb = '1;
        nxt_out = '0;
        for (int p = 0; p < NUM_PINS; p++)
            for (int d = 0; d < NUM_DESIGNS; d++)
                if (guard_cnt[p] == '0 && active_sel[p] == SEL_W'(d)) begin
                    nxt_oeb[p] = io_oeb_flat[d*NUM_PINS+p];
                    nxt_out[p] = io_out_flat[d*NUM_PINS+p];
                end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                shadow_sel[p] <= '1;
                active_sel[p] <= '1;
                guard_cnt[p] <= '0;
            end
            muxxed_io_oeb <= '1;
            muxxed_io_out <= '0;
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (cfg_we && addr_ok && cfg_addr == ADDR_W'(p)) shadow_sel[p] <= cfg_wdata;
                // commit reads the pre-write shadow, so a same-cycle write waits for the next commit
                if (commit_ok && shadow_sel[p] != active_sel[p]) begin
                    active_sel[p] <= shadow_sel[p];
                    guard_cnt[p] <= GW'(GUARD_CYCLES);
                end else if (guard_cnt[p] != '0) begin
                    guard_cnt[p] <= guard_cnt[p] - 1'b1;
                end
            end
            muxxed_io_oeb <= nxt_oeb;
            muxxed_io_out <= nxt_out;
        end
    end
endmodule
